inter_pred_chroma_fetch: RTL and testbench



---
 rtl/inter_pred_chroma_fetch_pkg.sv | 15 +
 rtl/inter_pred_chroma_fetch_chroma_row_extract.sv | 21 ++
 rtl/inter_pred_chroma_fetch.sv | 164 ++++++++++++++++
 tb/tb_inter_pred_chroma_fetch.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inter_pred_chroma_fetch_pkg.sv
// Shared types and constants for the chroma reference-patch fetcher.
package inter_pred_chroma_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_EMIT  = 2'd3
  } state_t;

  localparam int unsigned PATCH_DIM    = 5;
  localparam int unsigned ADDR_W_DEF   = 16;
  localparam int unsigned STRIDE_W_DEF = 8;

endpackage

// File: rtl/inter_pred_chroma_fetch_chroma_row_extract.sv
// Picks five consecutive pixels out of a 64-bit reference word, starting at byte_off.
module chroma_row_extract
  import inter_pred_chroma_fetch_pkg::*;
(
  input  logic [63:0] word,
  input  logic [1:0]  byte_off,
  output logic [39:0] pixels
);

  // byte_off+4 never exceeds 7, so a single word always holds the whole row
  always_comb begin
    pixels = '0;
    unique case (byte_off)
      2'd0:    pixels = word[39:0];
      2'd1:    pixels = word[47:8];
      2'd2:    pixels = word[55:16];
      default: pixels = word[63:24];
    endcase
  end

endmodule

// File: rtl/inter_pred_chroma_fetch.sv
// Fetches a 5x5 chroma reference patch and presents it as four 3x3 windows,
// one per 2x2 output quad, under a valid/ready handshake.
module inter_pred_chroma_fetch
  import inter_pred_chroma_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned STRIDE_W = STRIDE_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   ref_addr,
  input  logic [STRIDE_W-1:0] ref_stride,
  input  logic [1:0]          byte_off,
  input  logic [2:0]          xFracC_in,
  input  logic [2:0]          yFracC_in,
  output logic                busy,
  output logic                mem_rd,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [63:0]         mem_data,
  output logic                win_valid,
  input  logic                win_ready,
  output logic [1:0]          quad_idx,
  output logic [2:0]          xFracC,
  output logic [2:0]          yFracC,
  output logic [7:0]          Inter_C_window_0_0,
  output logic [7:0]          Inter_C_window_1_0,
  output logic [7:0]          Inter_C_window_2_0,
  output logic [7:0]          Inter_C_window_0_1,
  output logic [7:0]          Inter_C_window_1_1,
  output logic [7:0]          Inter_C_window_2_1,
  output logic [7:0]          Inter_C_window_0_2,
  output logic [7:0]          Inter_C_window_1_2,
  output logic [7:0]          Inter_C_window_2_2,
  output logic                done
);

  state_t                        state_q, state_d;
  logic [2:0]                    row_cnt_q;   // rows already issued
  logic [2:0]                    cap_row_q;   // next patch row to capture
  logic                          rd_q;        // read data arrives this cycle
  logic [ADDR_W-1:0]             base_q;
  logic [STRIDE_W-1:0]           stride_q;
  logic [1:0]                    off_q;
  logic [1:0]                    quad_q;
  logic [PATCH_DIM-1:0][7:0]     patch_q [PATCH_DIM];
  logic [PATCH_DIM-1:0][7:0]     row_pix;
  logic [STRIDE_W+2:0]           row_off;
  logic                          load, issue, accept;
  logic [2:0]                    r0, r1, r2, c0, c1, c2;

  chroma_row_extract u_row_extract (
    .word     (mem_data),
    .byte_off (off_q),
    .pixels   (row_pix)
  );

  assign row_off  = (STRIDE_W+3)'(row_cnt_q) * (STRIDE_W+3)'(stride_q);
  assign busy     = (state_q != ST_IDLE);
  assign quad_idx = quad_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_FETCH;
      ST_FETCH: if (row_cnt_q == 3'(PATCH_DIM)) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_EMIT;
      ST_EMIT:  if (win_ready && quad_q == 2'd3) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Per-state control strobes for the registered datapath
  always_comb begin
    load   = 1'b0;
    issue  = 1'b0;
    accept = 1'b0;
    unique case (state_q)
      ST_IDLE:  load   = start;
      ST_FETCH: issue  = (row_cnt_q != 3'(PATCH_DIM));
      ST_EMIT:  accept = win_ready;
      default:  ;
    endcase
  end

  // Registered datapath: address generation, row capture, window handshake
  // Row 0 is issued on the start edge itself, so the counter restarts at 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_cnt_q <= '0;
      cap_row_q <= '0;
      rd_q      <= 1'b0;
      base_q    <= '0;
      stride_q  <= '0;
      off_q     <= '0;
      quad_q    <= '0;
      xFracC    <= '0;
      yFracC    <= '0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      win_valid <= 1'b0;
      done      <= 1'b0;
      for (int unsigned r = 0; r < PATCH_DIM; r++) patch_q[r] <= '0;
    end else begin
      done   <= 1'b0;
      rd_q   <= mem_rd;
      mem_rd <= load | issue;
      if (load) begin
        base_q    <= ref_addr;
        stride_q  <= ref_stride;
        off_q     <= byte_off;
        xFracC    <= xFracC_in;
        yFracC    <= yFracC_in;
        mem_addr  <= ref_addr;
        row_cnt_q <= 3'd1;
        cap_row_q <= '0;
      end else if (issue) begin
        mem_addr  <= base_q + ADDR_W'(row_off);
        row_cnt_q <= row_cnt_q + 3'd1;
      end
      if (rd_q) begin
        patch_q[cap_row_q] <= row_pix;
        cap_row_q          <= cap_row_q + 3'd1;
      end
      if (state_q == ST_DRAIN) begin
        win_valid <= 1'b1;
        quad_q    <= '0;
      end
      if (accept) begin
        if (quad_q == 2'd3) begin
          win_valid <= 1'b0;
          done      <= 1'b1;
        end else begin
          quad_q <= quad_q + 2'd1;
        end
      end
    end
  end

  assign r0 = {quad_q[1], 1'b0};
  assign r1 = r0 + 3'd1;
  assign r2 = r0 + 3'd2;
  assign c0 = {quad_q[0], 1'b0};
  assign c1 = c0 + 3'd1;
  assign c2 = c0 + 3'd2;

  assign Inter_C_window_0_0 = patch_q[r0][c0];
  assign Inter_C_window_1_0 = patch_q[r0][c1];
  assign Inter_C_window_2_0 = patch_q[r0][c2];
  assign Inter_C_window_0_1 = patch_q[r1][c0];
  assign Inter_C_window_1_1 = patch_q[r1][c1];
  assign Inter_C_window_2_1 = patch_q[r1][c2];
  assign Inter_C_window_0_2 = patch_q[r2][c0];
  assign Inter_C_window_1_2 = patch_q[r2][c1];
  assign Inter_C_window_2_2 = patch_q[r2][c2];

endmodule

// File: tb/tb_inter_pred_chroma_fetch.sv
// Self-checking bench for inter_pred_chroma_fetch: table vectors, directed
// corner sequences and randomized blocks against a behavioural patch model.
module tb_inter_pred_chroma_fetch;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] ref_addr;
  logic [7:0]  ref_stride;
  logic [1:0]  byte_off;
  logic [2:0]  xFracC_in, yFracC_in;
  logic        busy, mem_rd, win_valid, win_ready, done;
  logic [15:0] mem_addr;
  logic [63:0] mem_data;
  logic [1:0]  quad_idx;
  logic [2:0]  xFracC, yFracC;
  logic [7:0]  w00, w10, w20, w01, w11, w21, w02, w12, w22;
  logic [7:0]  win [3][3];

  int          n_pass = 0;
  int          n_total = 0;
  int unsigned mem_seed = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  stride;
    logic [1:0]  off;
    logic [2:0]  xf;
    logic [2:0]  yf;
  } req_t;

  typedef struct packed {
    req_t             req;
    logic [4:0][15:0] ea;
    logic [31:0]      corners; // {q3 w22, q3 w00, q0 w22, q0 w00}
  } vec_t;

  inter_pred_chroma_fetch #(.ADDR_W(16), .STRIDE_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .ref_addr(ref_addr),
    .ref_stride(ref_stride), .byte_off(byte_off), .xFracC_in(xFracC_in),
    .yFracC_in(yFracC_in), .busy(busy), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_data(mem_data), .win_valid(win_valid), .win_ready(win_ready),
    .quad_idx(quad_idx), .xFracC(xFracC), .yFracC(yFracC),
    .Inter_C_window_0_0(w00), .Inter_C_window_1_0(w10), .Inter_C_window_2_0(w20),
    .Inter_C_window_0_1(w01), .Inter_C_window_1_1(w11), .Inter_C_window_2_1(w21),
    .Inter_C_window_0_2(w02), .Inter_C_window_1_2(w12), .Inter_C_window_2_2(w22),
    .done(done)
  );

  assign win[0][0] = w00; assign win[1][0] = w10; assign win[2][0] = w20;
  assign win[0][1] = w01; assign win[1][1] = w11; assign win[2][1] = w21;
  assign win[0][2] = w02; assign win[1][2] = w12; assign win[2][2] = w22;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference memory content: with seed 0 it is (addr*8+k)&0xFF
  function automatic logic [7:0] mem_byte(input logic [15:0] a, input int k);
    int unsigned v;
    v = (32'(a) * 8 + 32'(k)) ^ (mem_seed * (32'(a) + 1));
    return v[7:0];
  endfunction

  // One-cycle-latency memory
  always @(posedge clk) begin
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = mem_byte(mem_addr, k);
    if (mem_rd) mem_data <= w;
  end

  function automatic logic [15:0] row_addr(input req_t q, input int r);
    return 16'(32'(q.addr) + 32'(r) * 32'(q.stride));
  endfunction

  function automatic logic [7:0] ref_pix(input req_t q, input int r, input int c);
    return mem_byte(row_addr(q, r), 32'(q.off) + c);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mem_rd"}, mem_rd, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_win_valid"}, win_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_quad_idx"}, quad_idx, 0);
    chk({tag, "_xfrac"}, xFracC, 0);
    chk({tag, "_yfrac"}, yFracC, 0);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        chk($sformatf("%s_win_%0d_%0d", tag, i, j), win[i][j], 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_mem_rd", mem_rd, 0);
      chk("idle_win_valid", win_valid, 0);
      win_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Call at a negedge in an idle (or done) cycle; that cycle becomes cycle 0.
  // Returns in the done cycle, at its negedge.
  task automatic run_block(input req_t q, input logic [4:0][15:0] exp_addr,
                           input int stall_quad, input int stall_len,
                           input bit rnd_ready, input bit poke_start,
                           output int done_cyc, output logic [31:0] corners);
    int accepts;
    int stall_left;
    bit rdy;
    start = 1'b1; ref_addr = q.addr; ref_stride = q.stride; byte_off = q.off;
    xFracC_in = q.xf; yFracC_in = q.yf; win_ready = 1'b0;
    accepts = 0; stall_left = stall_len; done_cyc = -1; corners = '0;
    for (int n = 1; n <= 100 && done_cyc < 0; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (accepts == 4) begin
        chk("done_pulse", done, 1);
        chk("busy_at_done", busy, 0);
        chk("win_valid_at_done", win_valid, 0);
        done_cyc = n;
      end else begin
        chk("busy", busy, 1);
        chk("done_early", done, 0);
        if (n <= 5) begin
          chk("mem_rd_on", mem_rd, 1);
          chk($sformatf("mem_addr_row%0d", n - 1), mem_addr, exp_addr[n-1]);
        end else begin
          chk("mem_rd_off", mem_rd, 0);
        end
        if (n < 7) begin
          chk("win_valid_early", win_valid, 0);
        end else begin
          chk("win_valid", win_valid, 1);
          chk("quad_idx", quad_idx, accepts);
          chk("xFracC", xFracC, q.xf);
          chk("yFracC", yFracC, q.yf);
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              chk($sformatf("win_q%0d_%0d_%0d", accepts, i, j), win[i][j],
                  ref_pix(q, 2 * (accepts / 2) + j, 2 * (accepts % 2) + i));
          if (accepts == 0) begin corners[7:0] = win[0][0]; corners[15:8] = win[2][2]; end
          if (accepts == 3) begin corners[23:16] = win[0][0]; corners[31:24] = win[2][2]; end
          rdy = 1'b1;
          if (rnd_ready) rdy = ($urandom_range(0, 2) != 0);
          if (accepts == stall_quad && stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
            if (poke_start) begin
              start = 1'b1; ref_addr = ~q.addr; ref_stride = q.stride + 8'd1;
              byte_off = ~q.off; xFracC_in = ~q.xf; yFracC_in = ~q.yf;
            end
          end
          win_ready = rdy;
          if (rdy) accepts++;
        end
      end
    end
    if (done_cyc < 0) chk("done_timeout", 0, 1);
  endtask

  vec_t        vecs [4];
  int          dc;
  logic [31:0] cr;
  req_t        qa, qb;

  initial begin
    vecs[0] = '{req: '{addr: 16'h0100, stride: 8'd4, off: 2'd0, xf: 3'd1, yf: 3'd3},
                ea: {16'h0110, 16'h010C, 16'h0108, 16'h0104, 16'h0100},
                corners: 32'h8442_4200};
    vecs[1] = '{req: '{addr: 16'h0100, stride: 8'd4, off: 2'd3, xf: 3'd6, yf: 3'd0},
                ea: {16'h0110, 16'h010C, 16'h0108, 16'h0104, 16'h0100},
                corners: 32'h8745_4503};
    vecs[2] = '{req: '{addr: 16'hFFFE, stride: 8'd1, off: 2'd0, xf: 3'd7, yf: 3'd7},
                ea: {16'h0002, 16'h0001, 16'h0000, 16'hFFFF, 16'hFFFE},
                corners: 32'h1402_02F0};
    vecs[3] = '{req: '{addr: 16'h1234, stride: 8'h10, off: 2'd2, xf: 3'd2, yf: 3'd5},
                ea: {16'h1274, 16'h1264, 16'h1254, 16'h1244, 16'h1234},
                corners: 32'hA6A4_A4A2};

    reset = 1'b1; start = 1'b0; ref_addr = '0; ref_stride = '0; byte_off = '0;
    xFracC_in = '0; yFracC_in = '0; win_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    idle_cycles(2);

    // Table vectors with win_ready held high
    for (int v = 0; v < 4; v++) begin
      run_block(vecs[v].req, vecs[v].ea, -1, 0, 1'b0, 1'b0, dc, cr);
      chk($sformatf("vec%0d_corners", v), cr, vecs[v].corners);
      chk($sformatf("vec%0d_done_cycle", v), dc, 11);
      idle_cycles(2);
    end

    // Consumer stalls 3 cycles at quad 1 while start is pulsed
    qa = vecs[0].req; qa.xf = 3'd4; qa.yf = 3'd1;
    run_block(qa, vecs[0].ea, 1, 3, 1'b0, 1'b1, dc, cr);
    chk("stall_done_cycle", dc, 14);
    idle_cycles(2);

    // Reset in cycle 4 of a block
    start = 1'b1; ref_addr = 16'h0100; ref_stride = 8'd4; byte_off = 2'd1;
    xFracC_in = 3'd3; yFracC_in = 3'd6;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_mem_rd", mem_rd, 1);
    @(posedge clk); #1 reset = 1'b1;
    #1 chk_zero("mid_reset");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    idle_cycles(12);
    run_block(vecs[1].req, vecs[1].ea, -1, 0, 1'b0, 1'b0, dc, cr);
    chk("post_reset_corners", cr, vecs[1].corners);
    chk("post_reset_done_cycle", dc, 11);

    // Back-to-back: next start lands in the done cycle with new fractions
    qb = vecs[2].req; qb.xf = 3'd5; qb.yf = 3'd2;
    run_block(qb, vecs[2].ea, -1, 0, 1'b0, 1'b0, dc, cr);
    chk("chained_done_cycle", dc, 11);
    chk("chained_corners", cr, vecs[2].corners);
    idle_cycles(2);

    // Randomized blocks with random consumer backpressure
    for (int t = 0; t < 12; t++) begin
      req_t             q;
      logic [4:0][15:0] ea;
      mem_seed = $urandom;
      q.addr = 16'($urandom); q.stride = 8'($urandom); q.off = 2'($urandom);
      q.xf = 3'($urandom); q.yf = 3'($urandom);
      for (int r = 0; r < 5; r++) ea[r] = row_addr(q, r);
      run_block(q, ea, -1, 0, 1'b1, 1'b0, dc, cr);
      if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 3)));
    end
    idle_cycles(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
